led_period_meter: RTL and testbench

LED_PERIOD_METER -- requirements
Module: led_period_meter

---
 rtl/led_period_meter.sv | 103 ++++++++++
 tb/tb_led_period_meter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of an asynchronous
// LED/blink input and flags a stall when no rising edge arrives within TIMEOUT clocks.
module led_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             led,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             stalled,
  output logic [7:0]       edge_count
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;

  // s1/s2 resynchronise the asynchronous input; s3 is the one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= led;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      stalled    <= 1'b0;
      edge_count <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only establishes a reference; there is no interval to report yet
          if (rise) begin
            cnt        <= ONE;
            hcnt       <= ONE;
            edge_count <= edge_count + 8'd1;
            state      <= MEASURE;
          end
        end
        MEASURE: begin
          // A rise landing on the limit cycle still counts as a good period
          if (rise) begin
            period     <= cnt;
            valid      <= 1'b1;
            stalled    <= 1'b0;
            edge_count <= edge_count + 8'd1;
            cnt        <= ONE;
            hcnt       <= ONE;
          end else if (cnt == LIMIT) begin
            timeout <= 1'b1;
            stalled <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + ONE;
            if (s2) begin
              hcnt <= hcnt + ONE;
            end
            if (fall) begin
              high_time <= hcnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_period_meter.sv
// Directed table-driven bench for led_period_meter: each record drives one
// high/low waveform segment and compares the outputs seen at its end.
module tb_led_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             led;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             stalled;
  logic [7:0]       edge_count;

  led_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .led       (led),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .stalled   (stalled),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    bit do_reset;
    int pre_high;
    int nvalid;
    int ntimeout;
    int period;
    int high;
    int stalled;
    int edges;
    bit chk_lat;
  } vec_t;

  vec_t tbl [15];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int seg_step = 0;
  int seg_nvalid = 0;
  int seg_ntimeout = 0;
  int seg_vstep = 0;
  int last_vcyc = 0;
  int last_tcyc = 0;
  int overlap = 0;

  // One clock of stimulus; outputs are sampled 1 time unit after the edge
  task automatic step(input logic lv);
    led = lv;
    @(posedge clk);
    #1;
    cyc++;
    seg_step++;
    if (valid === 1'b1) begin
      seg_nvalid++;
      seg_vstep = seg_step;
      last_vcyc = cyc;
    end
    if (timeout === 1'b1) begin
      seg_ntimeout++;
      last_tcyc = cyc;
    end
    if (valid === 1'b1 && timeout === 1'b1) overlap++;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".period"}, int'(period), 0);
    checkOutput({tag, ".high_time"}, int'(high_time), 0);
    checkOutput({tag, ".valid"}, int'(valid), 0);
    checkOutput({tag, ".timeout"}, int'(timeout), 0);
    checkOutput({tag, ".stalled"}, int'(stalled), 0);
    checkOutput({tag, ".edge_count"}, int'(edge_count), 0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.do_reset) begin
      for (int i = 0; i < v.pre_high; i++) step(1'b1);
      reset = 1'b1;
      step(1'b0);
      step(1'b0);
      checkReset({tag, ".rst"});
      reset = 1'b0;
    end
    seg_step     = 0;
    seg_nvalid   = 0;
    seg_ntimeout = 0;
    seg_vstep    = 0;
    for (int i = 0; i < v.h; i++) step(1'b1);
    for (int i = 0; i < v.l; i++) step(1'b0);
    checkOutput({tag, ".nvalid"}, seg_nvalid, v.nvalid);
    checkOutput({tag, ".ntimeout"}, seg_ntimeout, v.ntimeout);
    checkOutput({tag, ".period"}, int'(period), v.period);
    checkOutput({tag, ".high_time"}, int'(high_time), v.high);
    checkOutput({tag, ".stalled"}, int'(stalled), v.stalled);
    checkOutput({tag, ".edge_count"}, int'(edge_count), v.edges);
    if (v.nvalid > 0) checkOutput({tag, ".valid_latency"}, seg_vstep, 3);
    if (v.chk_lat) checkOutput({tag, ".timeout_delay"}, last_tcyc - last_vcyc, TIMEOUT);
  endtask

  initial begin
    //            h    l   rst pre nv nt  per  hi st edg lat
    tbl[0]  = '{10,  10,  0, 0, 0, 0,   0, 10, 0,  1, 0};
    tbl[1]  = '{10,  10,  0, 0, 1, 0,  20, 10, 0,  2, 0};
    tbl[2]  = '{10,  10,  0, 0, 1, 0,  20, 10, 0,  3, 0};
    tbl[3]  = '{ 0, 120,  0, 0, 0, 1,  20, 10, 1,  3, 1};
    tbl[4]  = '{ 5,  25,  0, 0, 0, 0,  20,  5, 1,  4, 0};
    tbl[5]  = '{ 5,  25,  0, 0, 1, 0,  30,  5, 0,  5, 0};
    tbl[6]  = '{50,  50,  0, 0, 1, 0,  30, 50, 0,  6, 0};
    tbl[7]  = '{50,  50,  0, 0, 1, 0, 100, 50, 0,  7, 0};
    tbl[8]  = '{50,  50,  0, 0, 1, 0, 100, 50, 0,  8, 0};
    tbl[9]  = '{60,  41,  0, 0, 1, 0, 100, 60, 0,  9, 0};
    tbl[10] = '{ 3,   3,  0, 0, 0, 1, 100,  3, 1, 10, 1};
    tbl[11] = '{ 3,   3,  0, 0, 1, 0,   6,  3, 0, 11, 0};
    tbl[12] = '{10,  10,  1, 5, 0, 0,   0, 10, 0,  1, 0};
    tbl[13] = '{10,  10,  0, 0, 1, 0,  20, 10, 0,  2, 0};
    tbl[14] = '{120, 10,  0, 0, 1, 1,  20, 10, 1,  3, 1};

    reset = 1'b1;
    led   = 1'b0;
    step(1'b0);
    step(1'b0);
    checkReset("init");
    reset = 1'b0;

    for (int i = 0; i < 15; i++) applyStimulus(i, tbl[i]);

    checkOutput("valid_timeout_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
